conv1_frame_ctrl: RTL and testbench
===================================

Name: conv1_frame_ctrl

Overview:
Sequencer for the first convolution layer. On a start command it clears the layer's line buffer, then streams one WIDTH x HEIGHT 8-bit image from a synchronous image memory into the layer at one pixel per cycle. It counts the layer's valid output beats, then reports done, or reports an error if the count is wrong or the layer stalls. It sits between the top-level CNN control and the conv_layer_1 datapath, which has no handshake of its own.

Parameters:
WIDTH, 28, image columns
HEIGHT, 28, image rows
KSIZE, 5, convolution kernel size; expected outputs = (WIDTH-KSIZE+1)*(HEIGHT-KSIZE+1) = 576
DATA_BITS, 8, pixel width
ADDR_BITS, 10, image memory address width (must hold WIDTH*HEIGHT)
DRAIN_MAX, 64, max cycles after the last pixel to wait for remaining valid beats

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to process a frame; honoured only in IDLE
img_base  in  ADDR_BITS  frame base address, sampled when start is accepted
mem_rd_en  out  1  image memory read enable
mem_addr  out  ADDR_BITS  image memory read address
mem_rdata  in  DATA_BITS  read data, valid exactly 1 cycle after mem_rd_en
conv_rst_n  out  1  registered reset to conv layer line buffer/counters
conv_data_in  out  DATA_BITS  registered pixel to conv layer data_in
valid_out_conv  in  1  conv layer output-valid beat
busy  out  1  high from start acceptance until return to IDLE
done  out  1  one-cycle pulse at frame completion (success or error)
err  out  1  sticky error flag, cleared on next accepted start
out_count  out  10  valid beats counted in the current frame

Behaviour:
- Reset (async, rst_n=0): state=IDLE; mem_rd_en=0, mem_addr=0, conv_rst_n=0, conv_data_in=0, busy=0, done=0, err=0, out_count=0, all internal counters 0. conv_rst_n is released (1) on the first clock after reset deassertion.
- States: IDLE, CLR, FETCH, DRAIN, FIN.
- IDLE: on start=1, latch img_base, clear err and out_count, set busy, go to CLR. start while busy is ignored, with no side effects.
- CLR: conv_rst_n=0 for exactly 1 cycle, then go to FETCH with pixel index 0.
- FETCH: mem_rd_en=1 and mem_addr = base + idx (mod 2^ADDR_BITS) every cycle for idx 0..WIDTH*HEIGHT-1, with no bubbles. mem_rdata is registered into conv_data_in, so pixel idx reaches conv_data_in 2 cycles after its address cycle. After idx=WIDTH*HEIGHT-1 is issued, go to DRAIN; mem_rd_en=0 from then on.
- The data pipeline (rd_en delay and conv_data_in register) runs regardless of state. conv_data_in holds its last value when no read returns.
- DRAIN: the drain counter counts cycles from 0. Go to FIN when out_count reaches the expected count, or when the drain counter reaches DRAIN_MAX. Reaching DRAIN_MAX sets err.
- Counting: valid_out_conv is counted in FETCH and DRAIN only, saturating at 1023. A beat in CLR or IDLE is ignored. Counting beyond the expected count, or leaving DRAIN by timeout, sets err.
- FIN: done=1 for 1 cycle, busy drops in the same cycle, then go to IDLE. out_count holds its final value until the next accepted start.
- A start in the FIN cycle is ignored; start is accepted from the following IDLE cycle, giving a minimum gap of 1 cycle between frames.
- Reset mid-frame: everything returns to reset values immediately. conv_rst_n=0 also clears the layer.

Decomposition:
- Shared package cnn_pkg: IMG_W, IMG_H, KSIZE, OUT_PIX = (IMG_W-KSIZE+1)*(IMG_H-KSIZE+1), and a state enumeration constant set.
- One sub-module, frame_addr_gen: base latch, index counter, wrap-around address, and the last-pixel flag.
- The FSM and beat counter stay in the top module.

Test Plan:
- Normal frame: img_base=0, memory holds pattern addr[7:0], valid_out_conv is driven by the real conv_layer_1 -> conv_rst_n low 1 cycle; 784 consecutive reads; conv_data_in follows mem_rdata with 1-cycle lag; out_count=576; done pulse; err=0.
- Start during busy: pulse start again at idx 100 -> no restart, addresses stay contiguous, single done.
- Address wrap: img_base=1000 -> mem_addr runs 1000..1023, then 0..759; frame completes normally.
- Stall: model emits only 500 valid beats -> done exactly DRAIN_MAX=64 cycles after the last read, err=1, out_count=500.
- Over-count: model emits 580 beats -> err=1 at beat 577; done pulses; out_count=580.
- Reset mid-frame at idx 300, then a new start with img_base=0 -> all outputs at reset values during reset; second frame clean with out_count=576 and err=0.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants and FSM state encoding for the CNN layer-1 frame sequencer.
package cnn_pkg;

  localparam int unsigned IMG_W     = 28;
  localparam int unsigned IMG_H     = 28;
  localparam int unsigned KSIZE     = 5;
  localparam int unsigned OUT_PIX   = (IMG_W - KSIZE + 1) * (IMG_H - KSIZE + 1);
  localparam int unsigned PIX_BITS  = 8;
  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned DRAIN_LIM = 64;
  localparam int unsigned CNT_BITS  = 10;

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StFetch,
    StDrain,
    StFin
  } frame_state_e;

endpackage

// File: rtl/frame_addr_gen.sv
// Frame address generator: latches the frame base, walks the pixel index and flags the
// last pixel. Addresses wrap modulo 2^AddrBits.
module frame_addr_gen #(
  parameter int unsigned AddrBits = 10,
  parameter int unsigned NumPix   = 784
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic                step_i,
  input  logic [AddrBits-1:0] base_i,
  output logic [AddrBits-1:0] addr_o,
  output logic                last_o
);
  import cnn_pkg::*;

  logic [AddrBits-1:0] base_q, base_d;
  logic [AddrBits-1:0] idx_q, idx_d;

  always_comb begin
    base_d = base_q;
    idx_d  = idx_q;
    if (load_i) begin
      base_d = base_i;
      idx_d  = '0;
    end else if (step_i) begin
      idx_d = idx_q + AddrBits'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      idx_q  <= '0;
    end else begin
      base_q <= base_d;
      idx_q  <= idx_d;
    end
  end

  assign addr_o = base_q + idx_q;
  assign last_o = (idx_q == AddrBits'(NumPix - 1));

endmodule

// File: rtl/conv1_frame_ctrl.sv
// Frame sequencer for conv layer 1: clears the line buffer, streams one image from memory at
// one pixel per cycle, then checks the number of valid output beats the layer produced.
module conv1_frame_ctrl #(
  parameter int unsigned WIDTH     = cnn_pkg::IMG_W,
  parameter int unsigned HEIGHT    = cnn_pkg::IMG_H,
  parameter int unsigned KSIZE     = cnn_pkg::KSIZE,
  parameter int unsigned DATA_BITS = cnn_pkg::PIX_BITS,
  parameter int unsigned ADDR_BITS = cnn_pkg::ADDR_W,
  parameter int unsigned DRAIN_MAX = cnn_pkg::DRAIN_LIM
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] img_base,
  output logic                 mem_rd_en,
  output logic [ADDR_BITS-1:0] mem_addr,
  input  logic [DATA_BITS-1:0] mem_rdata,
  output logic                 conv_rst_n,
  output logic [DATA_BITS-1:0] conv_data_in,
  input  logic                 valid_out_conv,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [9:0]           out_count
);
  import cnn_pkg::*;

  localparam int unsigned NumPix    = WIDTH * HEIGHT;
  localparam int unsigned DrainBits = $clog2(DRAIN_MAX + 1);
  localparam logic [CNT_BITS-1:0] OutPix =
      CNT_BITS'((WIDTH - KSIZE + 1) * (HEIGHT - KSIZE + 1));
  localparam logic [CNT_BITS-1:0]  CntMax    = '1;
  localparam logic [DrainBits-1:0] DrainLast = DrainBits'(DRAIN_MAX - 1);

  frame_state_e         state_q, state_d;
  logic                 busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                 rd_en_q, rd_en_d, rd_dly_q, conv_rst_n_q, conv_rst_n_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic [DrainBits-1:0] drain_q, drain_d;
  logic                 load, step, last_pix, beat;

  frame_addr_gen #(
    .AddrBits(ADDR_BITS),
    .NumPix  (NumPix)
  ) u_addr_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .load_i(load),
    .step_i(step),
    .base_i(img_base),
    .addr_o(mem_addr),
    .last_o(last_pix)
  );

  assign beat = valid_out_conv && ((state_q == StFetch) || (state_q == StDrain));

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    load    = 1'b0;
    step    = 1'b0;

    // Beats past the expected total flag an error but are still counted (saturating).
    if (beat) begin
      cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_BITS'(1);
      if (cnt_q >= OutPix) err_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StClr;
          load    = 1'b1;
          err_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      StClr:   state_d = StFetch;
      StFetch: begin
        step    = 1'b1;
        drain_d = '0;
        if (last_pix) state_d = StDrain;
      end
      StDrain: begin
        drain_d = drain_q + DrainBits'(1);
        if (cnt_d >= OutPix) begin
          state_d = StFin;
        end else if (drain_q == DrainLast) begin
          state_d = StFin;
          err_d   = 1'b1;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    busy_d       = (state_d == StClr) || (state_d == StFetch) || (state_d == StDrain);
    done_d       = (state_d == StFin);
    rd_en_d      = (state_d == StFetch);
    conv_rst_n_d = (state_d != StClr);
    data_d       = rd_dly_q ? mem_rdata : data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_dly_q     <= 1'b0;
      conv_rst_n_q <= 1'b0;
      data_q       <= '0;
      cnt_q        <= '0;
      drain_q      <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      rd_en_q      <= rd_en_d;
      rd_dly_q     <= rd_en_q;
      conv_rst_n_q <= conv_rst_n_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      drain_q      <= drain_d;
    end
  end

  assign mem_rd_en    = rd_en_q;
  assign conv_rst_n   = conv_rst_n_q;
  assign conv_data_in = data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign out_count    = cnt_q;

endmodule

// File: tb/tb_conv1_frame_ctrl.sv
// Self-checking bench for conv1_frame_ctrl: table of frame scenarios plus hand-written
// sequences for reset, start in the FIN cycle and reset in mid-frame.
module tb_conv1_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] img_base = '0;
  logic       mem_rd_en;
  logic [9:0] mem_addr;
  logic [7:0] mem_rdata = '0;
  logic       conv_rst_n;
  logic [7:0] conv_data_in;
  logic       valid_out_conv;
  logic       busy, done, err;
  logic [9:0] out_count;

  int n_err = 0;
  int n_checks = 0;

  conv1_frame_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .img_base      (img_base),
    .mem_rd_en     (mem_rd_en),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .conv_rst_n    (conv_rst_n),
    .conv_data_in  (conv_data_in),
    .valid_out_conv(valid_out_conv),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .out_count     (out_count)
  );

  always #5 clk = ~clk;

  // Synchronous image memory: word at address a holds a[7:0].
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem_addr[7:0];

  // Layer model: one beat per 5x5 window position, one cycle after the pixel's address cycle.
  int beat_limit = 1023;
  int extra_n = 0;
  int pix_k, emitted;

  function automatic bit in_window(input int k);
    return ((k / 28) >= 4) && ((k % 28) >= 4);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out_conv <= 1'b0;
      pix_k <= 0;
      emitted <= 0;
    end else if (start && !busy) begin
      valid_out_conv <= 1'b0;
      pix_k <= 0;
      emitted <= 0;
    end else if (mem_rd_en) begin
      if ((in_window(pix_k) || pix_k < extra_n) && emitted < beat_limit) begin
        valid_out_conv <= 1'b1;
        emitted <= emitted + 1;
      end else begin
        valid_out_conv <= 1'b0;
      end
      pix_k <= pix_k + 1;
    end else begin
      valid_out_conv <= 1'b0;
    end
  end

  // Frame monitor, sampled on the falling edge.
  int cyc = 0;
  int rd_seen, addr_bad, data_bad, clr_low, done_n, done_t, last_rd_t, beats_obs, err_beat;
  int first_addr, last_addr, fbase;
  logic       d1_v = 1'b0, d2_v = 1'b0;
  logic [9:0] d1_a = '0, d2_a = '0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      d1_v = 1'b0;
      d2_v = 1'b0;
    end else begin
      if (mem_rd_en) begin
        if (rd_seen == 0) first_addr = int'(mem_addr);
        if (mem_addr != 10'(fbase + rd_seen)) addr_bad++;
        last_addr = int'(mem_addr);
        last_rd_t = cyc;
        rd_seen++;
      end
      if (d2_v && conv_data_in != d2_a[7:0]) data_bad++;
      d2_v = d1_v;
      d2_a = d1_a;
      d1_v = mem_rd_en;
      d1_a = mem_addr;
      if (!conv_rst_n) clr_low++;
      if (err && err_beat == 0) err_beat = beats_obs;
      if (valid_out_conv && busy && conv_rst_n) beats_obs++;
      if (done) begin
        done_n++;
        done_t = cyc;
      end
      if (start && !busy) begin
        rd_seen = 0; addr_bad = 0; data_bad = 0; clr_low = 0; done_n = 0;
        done_t = 0; last_rd_t = 0; beats_obs = 0; err_beat = 0;
        first_addr = -1; last_addr = -1; fbase = int'(img_base);
      end
    end
  end

  typedef struct {
    int base;
    int pulse_at;
    int limit;
    int extra;
    int exp_last;
    int exp_count;
    int exp_err;
    int exp_delay;
    int exp_err_beat;
  } frame_t;

  frame_t tbl [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic check_frame(input string tag, input frame_t f);
    check({tag, "_reads"}, rd_seen, 784);
    check({tag, "_addr_seq"}, addr_bad, 0);
    check({tag, "_first_addr"}, first_addr, f.base);
    check({tag, "_last_addr"}, last_addr, f.exp_last);
    check({tag, "_data_lag"}, data_bad, 0);
    check({tag, "_clr_cycles"}, clr_low, 1);
    check({tag, "_done_pulses"}, done_n, 1);
    check({tag, "_done_delay"}, done_t - last_rd_t - 1, f.exp_delay);
    check({tag, "_out_count"}, int'(out_count), f.exp_count);
    check({tag, "_err"}, int'(err), f.exp_err);
    check({tag, "_err_beat"}, err_beat, f.exp_err_beat);
    check({tag, "_busy_idle"}, int'(busy), 0);
  endtask

  task automatic run_frame(input frame_t f);
    bit pulsed = 1'b0;
    beat_limit = f.limit;
    extra_n = f.extra;
    img_base = 10'(f.base);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 2000 && done_n == 0; c++) begin
      if (f.pulse_at != 0 && !pulsed && rd_seen >= f.pulse_at) begin
        start = 1'b1;
        img_base = 10'd500;
        pulsed = 1'b1;
        tick();
        start = 1'b0;
      end else begin
        tick();
      end
    end
    repeat (4) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    //            base  pulse limit extra last  count err delay errbeat
    tbl[0] = '{   0,    0, 1023,    0, 783,  576,  0,    1,    0};  // normal
    tbl[1] = '{   0,  100, 1023,    0, 783,  576,  0,    1,    0};  // start while busy
    tbl[2] = '{1000,    0, 1023,    0, 759,  576,  0,    1,    0};  // address wrap
    tbl[3] = '{   0,    0,  500,    0, 783,  500,  1,   64,  500};  // stall -> timeout
    tbl[4] = '{   0,    0, 1023,    4, 783,  580,  1,    1,  577};  // over-count

    // Reset state.
    #12;
    check("rst_rd_addr", int'({mem_rd_en, mem_addr}), 0);
    check("rst_crst_data", int'({conv_rst_n, conv_data_in}), 0);
    check("rst_flags", int'({busy, done, err}), 0);
    check("rst_count", int'(out_count), 0);
    tick();
    rst_n = 1'b1;
    #1;
    check("crst_held", int'(conv_rst_n), 0);
    tick();
    check("crst_release", int'(conv_rst_n), 1);
    tick();

    for (int i = 0; i < 5; i++) begin
      run_frame(tbl[i]);
      check_frame($sformatf("frame%0d", i), tbl[i]);
    end

    // Start during the FIN cycle is ignored; the next IDLE cycle accepts it.
    beat_limit = 1023;
    extra_n = 0;
    img_base = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) tick();
    check("fin_done_seen", int'(done), 1);
    start = 1'b1;
    tick();
    check("fin_start_ignored", int'(busy), 0);
    tick();
    check("start_after_fin", int'(busy), 1);
    start = 1'b0;
    for (int c = 0; c < 2000 && done_n == 0; c++) tick();
    repeat (4) tick();
    check_frame("after_fin", tbl[0]);

    // Reset in mid-frame, then a clean frame.
    img_base = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 2000 && rd_seen < 300; c++) tick();
    check("midrst_reached", int'(rd_seen >= 300), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_rd_addr", int'({mem_rd_en, mem_addr}), 0);
    check("midrst_crst_data", int'({conv_rst_n, conv_data_in}), 0);
    check("midrst_flags", int'({busy, done, err}), 0);
    check("midrst_count", int'(out_count), 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    run_frame(tbl[0]);
    check_frame("post_rst", tbl[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
